joybus_tx_sequencer: RTL and testbench



---
 rtl/joybus_tx_sequencer.sv | 174 +++++++++++++++++
 tb/tb_joybus_tx_sequencer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/joybus_tx_sequencer.sv
// rtl/joybus_tx_sequencer.sv - Joybus response frame serializer: 4-level bit cells, controller stop bit, abort and reject handling
module joybus_tx_sequencer #(
    parameter int LEVEL_WIDTH = 2,
    parameter int MAX_BYTES   = 4
) (
    input  logic        sample_clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [2:0]  byte_count,
    input  logic [31:0] tx_data,
    input  logic        abort,
    output logic        data_tx,
    output logic        data_oe,
    output logic        busy,
    output logic        done,
    output logic        reject
);

    localparam int              CYC_W    = (LEVEL_WIDTH > 1) ? $clog2(LEVEL_WIDTH) : 1;
    localparam int              BIT_W    = $clog2(8 * MAX_BYTES + 1);
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(LEVEL_WIDTH - 1);
    localparam logic [2:0]      MAX_BC   = 3'(MAX_BYTES);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_SEND_BIT  = 2'd1,
        S_SEND_STOP = 2'd2,
        S_FINISH    = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CYC_W-1:0]   r_cyc;
    logic [1:0]         r_lvl;
    logic [BIT_W-1:0]   r_bit;
    logic [31:0]        r_shift;
    logic [2:0]         r_nbytes;
    logic               r_reject;

    logic               w_sending;
    logic               w_abort;
    logic               w_can_start;
    logic               w_len_ok;
    logic               w_load;
    logic               w_refuse;
    logic               w_level_end;
    logic               w_bit_end;
    logic               w_last_bit;
    logic [BIT_W-1:0]   w_total_bits;
    logic               w_tx;
    logic               w_oe;
    logic               w_busy;
    logic               w_done;

    assign w_sending    = (r_state == S_SEND_BIT) || (r_state == S_SEND_STOP);
    assign w_abort      = w_sending && abort;
    // FINISH behaves like IDLE for start so back-to-back frames lose only one cycle
    assign w_can_start  = (r_state == S_IDLE) || (r_state == S_FINISH);
    assign w_len_ok     = (byte_count != 3'd0) && (byte_count <= MAX_BC);
    assign w_load       = w_can_start && start && w_len_ok;
    assign w_refuse     = w_can_start && start && !w_len_ok;
    assign w_level_end  = (r_cyc == CYC_LAST);
    assign w_bit_end    = w_level_end && (r_lvl == 2'd3);
    assign w_total_bits = BIT_W'({r_nbytes, 3'b000});
    assign w_last_bit   = (r_bit == (w_total_bits - BIT_W'(1)));

    always_ff @(posedge sample_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_busy      = 1'b0;
        w_oe        = 1'b0;
        w_tx        = 1'b1;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_load) begin
                    w_state_nxt = S_SEND_BIT;
                end
            end
            S_SEND_BIT: begin
                w_busy = 1'b1;
                w_oe   = 1'b1;
                // Cell shape: L, bit, bit, H
                if (r_lvl == 2'd0) begin
                    w_tx = 1'b0;
                end else if (r_lvl == 2'd3) begin
                    w_tx = 1'b1;
                end else begin
                    w_tx = r_shift[31];
                end
                if (abort) begin
                    w_state_nxt = S_IDLE;
                end else if (w_bit_end && w_last_bit) begin
                    w_state_nxt = S_SEND_STOP;
                end
            end
            S_SEND_STOP: begin
                w_busy = 1'b1;
                w_oe   = (r_lvl != 2'd3);
                w_tx   = r_lvl[1];
                if (abort) begin
                    w_state_nxt = S_IDLE;
                end else if (w_bit_end) begin
                    w_state_nxt = S_FINISH;
                end
            end
            S_FINISH: begin
                w_done      = 1'b1;
                w_state_nxt = w_load ? S_SEND_BIT : S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge sample_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cyc    <= '0;
            r_lvl    <= 2'd0;
            r_bit    <= '0;
            r_shift  <= 32'd0;
            r_nbytes <= 3'd0;
        end else if (w_load) begin
            r_cyc    <= '0;
            r_lvl    <= 2'd0;
            r_bit    <= '0;
            r_shift  <= tx_data;
            r_nbytes <= byte_count;
        end else if (w_abort) begin
            r_cyc    <= '0;
            r_lvl    <= 2'd0;
            r_bit    <= '0;
        end else if (w_sending) begin
            if (w_level_end) begin
                r_cyc <= '0;
                if (r_lvl == 2'd3) begin
                    r_lvl <= 2'd0;
                    // Stop bit reuses the level counters but does not consume payload
                    if (r_state == S_SEND_BIT) begin
                        r_bit   <= r_bit + BIT_W'(1);
                        r_shift <= {r_shift[30:0], 1'b0};
                    end
                end else begin
                    r_lvl <= r_lvl + 2'd1;
                end
            end else begin
                r_cyc <= r_cyc + CYC_W'(1);
            end
        end
    end

    always_ff @(posedge sample_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_reject <= 1'b0;
        end else begin
            r_reject <= w_refuse;
        end
    end

    assign data_tx = w_tx;
    assign data_oe = w_oe;
    assign busy    = w_busy;
    assign done    = w_done;
    assign reject  = r_reject;

endmodule

// File: tb/tb_joybus_tx_sequencer.sv
// tb/tb_joybus_tx_sequencer.sv - self-checking bench for joybus_tx_sequencer (LEVEL_WIDTH=2, MAX_BYTES=4)
module tb_joybus_tx_sequencer;

    localparam int LW = 2;

    logic        sample_clk = 1'b0;
    logic        reset_n    = 1'b0;
    logic        start      = 1'b0;
    logic        abort      = 1'b0;
    logic [2:0]  byte_count = 3'd0;
    logic [31:0] tx_data    = 32'd0;
    logic        data_tx;
    logic        data_oe;
    logic        busy;
    logic        done;
    logic        reject;

    int n_cmp = 0;
    int n_err = 0;
    // Line symbols: 0 = driven low, 1 = driven high, 2 = released, 3 = released but data_tx low
    int exp_q[$];

    typedef struct {
        logic [2:0]  bc;
        logic [31:0] data;
        int          exp_busy;
    } vec_t;
    vec_t vecs[7];

    always #5 sample_clk = ~sample_clk;

    joybus_tx_sequencer #(
        .LEVEL_WIDTH(LW),
        .MAX_BYTES  (4)
    ) dut (
        .sample_clk(sample_clk),
        .reset_n   (reset_n),
        .start     (start),
        .byte_count(byte_count),
        .tx_data   (tx_data),
        .abort     (abort),
        .data_tx   (data_tx),
        .data_oe   (data_oe),
        .busy      (busy),
        .done      (done),
        .reject    (reject)
    );

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int line_sym();
        if (data_oe === 1'b1) return (data_tx === 1'b1) ? 1 : 0;
        return (data_tx === 1'b1) ? 2 : 3;
    endfunction

    // Reference waveform built straight from the cell definitions
    task automatic push_frame(input logic [2:0] bc, input logic [31:0] data);
        int lv[4];
        for (int i = 0; i < 8 * int'(bc); i++) begin
            int b;
            b = int'(data[31-i]);
            lv = '{0, b, b, 1};
            for (int l = 0; l < 4; l++)
                for (int k = 0; k < LW; k++) exp_q.push_back(lv[l]);
        end
        lv = '{0, 0, 1, 2};
        for (int l = 0; l < 4; l++)
            for (int k = 0; k < LW; k++) exp_q.push_back(lv[l]);
    endtask

    task automatic watch(input int exp_busy, input int inj_at, input bit restart,
                         input logic [2:0] nbc, input logic [31:0] ndata);
        int n_busy = 0, n_done = 0, n_good_done = 0, n_rej = 0, n_bad_oe = 0;
        int first_busy = -1;
        int ncyc;
        bit prev_busy = 1'b0;
        bit hit = 1'b0;
        ncyc = exp_busy + 4;
        for (int c = 0; c < ncyc; c++) begin
            @(posedge sample_clk);
            #1;
            start = 1'b0;
            abort = 1'b0;
            if (busy === 1'b1) begin
                n_busy++;
                if (first_busy < 0) first_busy = c;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL sb_underflow: cycle %0d got line %0d expected idle", c, line_sym());
                end else begin
                    check($sformatf("line[c%0d]", c), line_sym(), exp_q.pop_front());
                end
            end else if (data_oe !== 1'b0) begin
                n_bad_oe++;
            end
            if (reject === 1'b1) n_rej++;
            if (done === 1'b1) begin
                n_done++;
                if (prev_busy && busy === 1'b0 && data_oe === 1'b0) n_good_done++;
            end
            prev_busy = (busy === 1'b1);
            if (c == inj_at) begin
                start      = 1'b1;
                byte_count = 3'd2;
                tx_data    = 32'hFFFF_FFFF;
            end
            if (done === 1'b1 && restart) begin
                hit = 1'b1;
                break;
            end
        end
        check("busy_cycles", n_busy, exp_busy);
        check("done_pulses", n_done, (exp_busy > 0) ? 1 : 0);
        check("done_at_busy_fall", n_good_done, (exp_busy > 0) ? 1 : 0);
        check("reject_pulses", n_rej, (exp_busy > 0) ? 0 : 1);
        check("oe_while_not_busy", n_bad_oe, 0);
        check("sb_leftover", exp_q.size(), 0);
        if (exp_busy > 0) check("first_busy_cycle", first_busy, 0);
        exp_q.delete();
        if (hit) begin
            push_frame(nbc, ndata);
            start      = 1'b1;
            byte_count = nbc;
            tx_data    = ndata;
        end
    endtask

    task automatic run_frame(input logic [2:0] bc, input logic [31:0] data, input int exp_busy,
                             input int inj_at, input bit restart,
                             input logic [2:0] nbc, input logic [31:0] ndata);
        if (exp_busy > 0) push_frame(bc, data);
        start      = 1'b1;
        byte_count = bc;
        tx_data    = data;
        watch(exp_busy, inj_at, restart, nbc, ndata);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_oe"},     int'(data_oe), 0);
        check({tag, "_tx"},     int'(data_tx), 1);
        check({tag, "_busy"},   int'(busy),    0);
        check({tag, "_done"},   int'(done),    0);
        check({tag, "_reject"}, int'(reject),  0);
    endtask

    initial begin
        int n_busy;
        int n_done;

        vecs[0] = '{3'd1, 32'h8000_0000, 72};
        vecs[1] = '{3'd3, 32'h0500_0000, 200};
        vecs[2] = '{3'd0, 32'h1234_5678, 0};
        vecs[3] = '{3'd5, 32'h1234_5678, 0};
        vecs[4] = '{3'd2, 32'hA55A_0000, 136};
        vecs[5] = '{3'd4, 32'hDEAD_BEEF, 264};
        vecs[6] = '{3'd7, 32'hFFFF_FFFF, 0};

        repeat (3) @(posedge sample_clk);
        #1;
        check_reset_outputs("reset");
        reset_n = 1'b1;

        for (int i = 0; i < 7; i++)
            run_frame(vecs[i].bc, vecs[i].data, vecs[i].exp_busy, -1, 1'b0, 3'd0, 32'd0);

        // Start mid-frame is ignored; start in the done cycle chains a new frame
        run_frame(3'd1, 32'hA500_0000, 72, 10, 1'b1, 3'd1, 32'h3C00_0000);
        watch(72, -1, 1'b0, 3'd0, 32'd0);

        // Start wins over abort in the same idle cycle
        abort = 1'b1;
        run_frame(3'd2, 32'h1234_0000, 136, -1, 1'b0, 3'd0, 32'd0);

        abort = 1'b1;
        repeat (3) @(posedge sample_clk);
        #1;
        check("idle_abort_busy", int'(busy), 0);
        check("idle_abort_oe", int'(data_oe), 0);
        abort = 1'b0;

        // Abort at frame cycle 20 of a 4-byte frame
        start      = 1'b1;
        byte_count = 3'd4;
        tx_data    = 32'hDEAD_BEEF;
        n_busy     = 0;
        for (int c = 0; c <= 20; c++) begin
            @(posedge sample_clk);
            #1;
            start = 1'b0;
            if (busy === 1'b1) n_busy++;
            if (c == 20) abort = 1'b1;
        end
        check("abort_pre_busy", n_busy, 21);
        @(posedge sample_clk);
        #1;
        abort = 1'b0;
        check("abort_oe", int'(data_oe), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_tx", int'(data_tx), 1);
        n_done = 0;
        for (int c = 0; c < 260; c++) begin
            @(posedge sample_clk);
            #1;
            if (done === 1'b1) n_done++;
        end
        check("abort_no_done", n_done, 0);

        // Asynchronous reset between edges in the middle of a frame
        start      = 1'b1;
        byte_count = 3'd3;
        tx_data    = 32'hF0F0_F000;
        @(posedge sample_clk);
        #1;
        start = 1'b0;
        repeat (30) @(posedge sample_clk);
        #1;
        check("pre_reset_busy", int'(busy), 1);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        #2;
        reset_n = 1'b1;
        run_frame(3'd1, 32'h8000_0000, 72, -1, 1'b0, 3'd0, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
